// File: rtl/uart_pkg.sv
// Shared UART definitions: frame size, receiver state encoding and the
// bit-period calculation used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int MAX_BIT_CNT = 8;

  typedef enum logic [2:0] {
    s_IDLE  = 3'd0,
    s_START = 3'd1,
    s_DATA  = 3'd2,
    s_STOP  = 3'd3,
    s_BREAK = 3'd4
  } rx_state_t;

  // Clock cycles per bit minus one, rounded to the nearest integer.
  function automatic int calc_max_cycle_cnt(input longint sys_clock, input longint baudrate);
    return int'((((sys_clock * 10) / baudrate) + 5) / 10 - 1);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_ResetN,
  input  logic i_Async,
  output logic o_Sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_Clock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_Async;
      r_sync <= r_meta;
    end
  end

  assign o_Sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid / frame-error pulses.
// Optional 2-of-3 majority sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYS_CLOCK     = 50000000,
  parameter int UART_BAUDRATE = 115200
) (
  input  logic       i_SysClock,
  input  logic       i_ResetN,
  input  logic       i_RxSerial,
  output logic [7:0] o_RxByte,
  output logic       o_RxValid,
  output logic       o_FrameErr,
  output logic       o_RxBusy
);

  localparam int MAX_CYCLE_CNT  = calc_max_cycle_cnt(longint'(SYS_CLOCK), longint'(UART_BAUDRATE));
  localparam int HALF_CYCLE_CNT = MAX_CYCLE_CNT / 2;
  localparam int CNT_W          = $clog2(MAX_CYCLE_CNT) + 1;
  localparam int BIT_W          = $clog2(MAX_BIT_CNT + 1);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLE_CNT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_CYCLE_CNT);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MAX_BIT_CNT - 1);

  rx_state_t        r_state;
  rx_state_t        w_state_next;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] w_cycle_cnt_next;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [BIT_W-1:0] w_bit_cnt_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic [7:0]       r_rx_byte;
  logic [7:0]       w_rx_byte_next;
  logic             r_rx_valid;
  logic             w_rx_valid_next;
  logic             r_frame_err;
  logic             w_frame_err_next;
  logic             w_rx_sync;
  logic             w_rx_sample;
  logic [CNT_W-1:0] w_start_cnt;

  uart_rx_sync u_sync (
    .i_Clock  (i_SysClock),
    .i_ResetN (i_ResetN),
    .i_Async  (i_RxSerial),
    .o_Sync   (w_rx_sync)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two previous rx_sync values; with the current one they form the vote window,
  // so every decision lands one cycle after the nominal sample point.
  logic [1:0] r_hist;

  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rx_sync};
    end
  end

  assign w_rx_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_sync) | (r_hist[0] & w_rx_sync);
  assign w_start_cnt = HALF_CNT + 1'b1;
`else
  assign w_rx_sample = w_rx_sync;
  assign w_start_cnt = HALF_CNT;
`endif

  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_state     <= s_IDLE;
      r_cycle_cnt <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_byte   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cycle_cnt <= w_cycle_cnt_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_shift     <= w_shift_next;
      r_rx_byte   <= w_rx_byte_next;
      r_rx_valid  <= w_rx_valid_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cycle_cnt_next = r_cycle_cnt;
    w_bit_cnt_next   = r_bit_cnt;
    w_shift_next     = r_shift;
    w_rx_byte_next   = r_rx_byte;
    w_rx_valid_next  = 1'b0;
    w_frame_err_next = 1'b0;
    case (r_state)
      s_IDLE: begin
        w_cycle_cnt_next = '0;
        if (!w_rx_sync) begin
          w_state_next = s_START;
        end
      end
      s_START: begin
        if (r_cycle_cnt == w_start_cnt) begin
          w_cycle_cnt_next = '0;
          w_bit_cnt_next   = '0;
          w_state_next     = w_rx_sample ? s_IDLE : s_DATA;
        end else begin
          w_cycle_cnt_next = r_cycle_cnt + 1'b1;
        end
      end
      s_DATA: begin
        if (r_cycle_cnt == MAX_CNT) begin
          w_cycle_cnt_next = '0;
          w_shift_next     = {w_rx_sample, r_shift[7:1]};
          w_bit_cnt_next   = r_bit_cnt + 1'b1;
          if (r_bit_cnt == BIT_LAST) begin
            w_state_next = s_STOP;
          end
        end else begin
          w_cycle_cnt_next = r_cycle_cnt + 1'b1;
        end
      end
      s_STOP: begin
        if (r_cycle_cnt == MAX_CNT) begin
          w_cycle_cnt_next = '0;
          if (w_rx_sample) begin
            w_rx_byte_next  = r_shift;
            w_rx_valid_next = 1'b1;
            w_state_next    = s_IDLE;
          end else begin
            w_frame_err_next = 1'b1;
            w_state_next     = s_BREAK;
          end
        end else begin
          w_cycle_cnt_next = r_cycle_cnt + 1'b1;
        end
      end
      s_BREAK: begin
        // Hold here while the line stays low so a break cannot look like a start bit.
        w_cycle_cnt_next = '0;
        if (w_rx_sync) begin
          w_state_next = s_IDLE;
        end
      end
      default: begin
        w_state_next     = s_IDLE;
        w_cycle_cnt_next = '0;
      end
    endcase
  end

  assign o_RxByte   = r_rx_byte;
  assign o_RxValid  = r_rx_valid;
  assign o_FrameErr = r_frame_err;
  assign o_RxBusy   = (r_state != s_IDLE);

endmodule
